midi_uart_rx: RTL and testbench

//   MIDI serial receiver (8N1, 31250 baud) feeding the synth parameter decoder inside nexys_audio_top.

---
 rtl/midi_uart_rx.sv | 170 +++++++++++++++++
 tb/tb_midi_uart_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 serial receiver: two-flop input synchroniser, 16x oversampling with a
// 3-sample majority vote per bit, registered 1-cycle valid / frame_err strobes.
module midi_uart_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 31_250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  // state   | meaning
  // S_IDLE  | line idle, waiting for rx_s low (start edge)
  // S_START | qualifying start bit; majority high means glitch
  // S_DATA  | shifting in 8 data bits, LSB first
  // S_STOP  | sampling stop bit; high forwards byte, low flags frame_err
  // S_BREAK | after bad stop: wait for 16 consecutive high ticks

  localparam int TICK_DIV = CLK_HZ / (BAUD * 16);
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    s_cnt;
  logic [1:0]    samp;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          decide;
  logic          maj;
  logic          brk_done;

  logic          cnt_clr;
  logic          shift_en;
  logic          load_data;
  logic          set_valid;
  logic          set_ferr;

  // s_cnt counts ticks elapsed within the current bit, so the tick seen while
  // s_cnt==8 is the one that moves the bit into sample index 9.
  assign tick     = (tick_cnt == TICK_LAST);
  assign decide   = tick && (s_cnt == 4'd8);
  assign maj      = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign brk_done = tick && rx_s && (s_cnt == 4'd15);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    load_data = 1'b0;
    set_valid = 1'b0;
    set_ferr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (decide) begin
          state_n = maj ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (decide) begin
          if (maj) begin
            load_data = 1'b1;
            set_valid = 1'b1;
            state_n   = S_IDLE;
          end else begin
            set_ferr = 1'b1;
            cnt_clr  = 1'b1;
            state_n  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Any low sample restarts the high-time qualification.
        if (!rx_s) begin
          cnt_clr = 1'b1;
        end else if (brk_done) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      tick_cnt  <= '0;
      s_cnt     <= 4'd0;
      samp      <= 2'b00;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_n;
      valid     <= set_valid;
      frame_err <= set_ferr;

      if (cnt_clr || (state == S_IDLE)) begin
        tick_cnt <= '0;
        s_cnt    <= 4'd0;
      end else if (tick) begin
        tick_cnt <= '0;
        s_cnt    <= s_cnt + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (tick && (s_cnt == 4'd6)) begin
        samp[0] <= rx_s;
      end
      if (tick && (s_cnt == 4'd7)) begin
        samp[1] <= rx_s;
      end

      if (state == S_START) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (shift_en) begin
        shift_reg <= {maj, shift_reg[7:1]};
      end

      if (load_data) begin
        data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx: 2 MHz clock, 31250 baud, so 4 clk per tick
// and 64 clk (32 us) per nominal bit.
`timescale 1ns/1ps
module tb_midi_uart_rx;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  midi_uart_rx #(.CLK_HZ(2_000_000), .BAUD(31_250)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #250 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int nvalid  = 0;
  int nferr   = 0;
  int nboth   = 0;
  int nlong   = 0;
  int t_start = 0;
  logic valid_d = 1'b0;
  logic ferr_d  = 1'b0;
  logic [7:0] data_q[$];
  int         vcyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && frame_err) nboth++;
    if ((valid && valid_d) || (frame_err && ferr_d)) nlong++;
    if (valid) begin
      nvalid++;
      data_q.push_back(data);
      vcyc_q.push_back(cyc);
    end
    if (frame_err) nferr++;
    valid_d = valid;
    ferr_d  = frame_err;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop);
    t_start = cyc;
    rx = 1'b0;
    wait_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bit_clks);
    end
    rx = stop;
    wait_clks(bit_clks);
  endtask

  typedef struct {
    logic [7:0] b;
    int         bit_clks;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, f0, lat;

    vecs[0] = '{8'h2F, 64, 8'h2F};
    vecs[1] = '{8'h55, 62, 8'h55};
    vecs[2] = '{8'hAA, 62, 8'hAA};
    vecs[3] = '{8'h55, 66, 8'h55};
    vecs[4] = '{8'hAA, 66, 8'hAA};
    vecs[5] = '{8'h00, 64, 8'h00};
    vecs[6] = '{8'hFF, 64, 8'hFF};

    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(2);
    check("reset data", int'(data), 8'h00);
    check("reset valid", int'(valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset busy", int'(busy), 0);

    // Nominal and +/-3% rate frames; 62/66 clk per bit is about 3.1% off nominal.
    for (int i = 0; i < 7; i++) begin
      v0 = nvalid;
      f0 = nferr;
      send_frame(vecs[i].b, vecs[i].bit_clks, 1'b1);
      wait_clks(2 * BIT);
      check($sformatf("vec%0d valid count", i), nvalid - v0, 1);
      check($sformatf("vec%0d frame_err count", i), nferr - f0, 0);
      check($sformatf("vec%0d data", i), int'(data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d busy idle", i), int'(busy), 0);
      if (vecs[i].bit_clks == BIT) begin
        lat = (vcyc_q.size() > 0) ? vcyc_q[$] - t_start : -1;
        check($sformatf("vec%0d latency 613..617", i), int'(lat >= 613 && lat <= 617), 1);
      end
    end

    // Back-to-back frames with a single stop bit and no gap.
    v0 = nvalid;
    f0 = nferr;
    data_q.delete();
    vcyc_q.delete();
    send_frame(8'h61, BIT, 1'b1);
    send_frame(8'hE5, BIT, 1'b1);
    wait_clks(2 * BIT);
    check("b2b valid count", nvalid - v0, 2);
    check("b2b frame_err count", nferr - f0, 0);
    check("b2b first byte", (data_q.size() > 0) ? int'(data_q[0]) : -1, 8'h61);
    check("b2b second byte", (data_q.size() > 1) ? int'(data_q[1]) : -1, 8'hE5);
    check("b2b spacing", (vcyc_q.size() > 1) ? vcyc_q[1] - vcyc_q[0] : -1, 10 * BIT);

    // 1 us (2 clk) low glitch on an idle line.
    v0 = nvalid;
    f0 = nferr;
    rx = 1'b0;
    wait_clks(2);
    rx = 1'b1;
    wait_clks(8);
    check("glitch busy during", int'(busy), 1);
    wait_clks(BIT - 8);
    check("glitch busy after", int'(busy), 0);
    check("glitch valid count", nvalid - v0, 0);
    check("glitch frame_err count", nferr - f0, 0);

    // Bad stop bit followed by a long break, then a good frame.
    v0 = nvalid;
    f0 = nferr;
    send_frame(8'hA5, BIT, 1'b0);
    wait_clks(10 * BIT);
    check("break frame_err count", nferr - f0, 1);
    check("break valid count", nvalid - v0, 0);
    check("break data held", int'(data), 8'hE5);
    check("break busy held", int'(busy), 1);
    rx = 1'b1;
    wait_clks(2 * BIT);
    check("break busy released", int'(busy), 0);
    check("break no repeat err", nferr - f0, 1);
    send_frame(8'h3C, BIT, 1'b1);
    wait_clks(2 * BIT);
    check("after break valid", nvalid - v0, 1);
    check("after break data", int'(data), 8'h3C);

    // Reset pulse in the middle of bit 4 of 8'hFF.
    rx = 1'b0;
    wait_clks(BIT);
    rx = 1'b1;
    wait_clks(4 * BIT + BIT / 2);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    v0 = nvalid;
    f0 = nferr;
    check("mid rst data", int'(data), 8'h00);
    check("mid rst busy", int'(busy), 0);
    check("mid rst valid", int'(valid), 0);
    wait_clks(BIT / 2 + 4 * BIT + 2 * BIT);
    check("mid rst no valid", nvalid - v0, 0);
    check("mid rst no frame_err", nferr - f0, 0);
    send_frame(8'h12, BIT, 1'b1);
    wait_clks(2 * BIT);
    check("post rst valid", nvalid - v0, 1);
    check("post rst data", int'(data), 8'h12);

    check("strobes exclusive", nboth, 0);
    check("strobes one cycle", nlong, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
